// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC sequencing, ROM fetch and instruction register; optional FETCH_WRAP_FAULT_EN
module instr_fetch #(
    parameter int         D         = 12,
    parameter logic [8:0] HALT_CODE = 9'b111111111,
    parameter int         OFS_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [D-1:0]     start_addr,
    input  logic             stall,
    input  logic             br_rel,
    input  logic [OFS_W-1:0] br_offset,
    input  logic             jmp_abs,
    input  logic [D-1:0]     jmp_target,
    output logic [D-1:0]     prog_ctr_out,
    input  logic [8:0]       mach_code,
    output logic [8:0]       instr,
    output logic [D-1:0]     instr_pc,
    output logic             instr_valid,
    output logic             done,
    output logic             fault
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t         state_q, state_d;
    logic [D-1:0]   pc_q, pc_d;
    logic [D-1:0]   instr_pc_q, instr_pc_d;
    logic [8:0]     instr_q, instr_d;
    logic           valid_q, valid_d;
    logic           done_q, done_d;
    logic [D-1:0]   rel_target;

    // Size cast of a signed operand sign-extends the offset before the modulo-2**D add.
    assign rel_target = instr_pc_q + D'($signed(br_offset));

`ifdef FETCH_WRAP_FAULT_EN
    logic fault_q, fault_d;
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        done_d     = done_q;
`ifdef FETCH_WRAP_FAULT_EN
        fault_d    = fault_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = start_addr;
                    valid_d = 1'b0;
                    done_d  = 1'b0;
`ifdef FETCH_WRAP_FAULT_EN
                    fault_d = 1'b0;
`endif
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    if (valid_q && instr_q == HALT_CODE) begin
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else if (valid_q && jmp_abs) begin
                        pc_d    = jmp_target;
                        valid_d = 1'b0;
                    end else if (valid_q && br_rel) begin
                        pc_d    = rel_target;
                        valid_d = 1'b0;
`ifdef FETCH_WRAP_FAULT_EN
                    end else if (&pc_q) begin
                        // Last ROM word is reserved: reaching it ends the run with a fault.
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        fault_d = 1'b1;
`endif
                    end else begin
                        instr_d    = mach_code;
                        instr_pc_d = pc_q;
                        valid_d    = 1'b1;
                        pc_d       = pc_q + D'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
`ifdef FETCH_WRAP_FAULT_EN
            fault_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
`ifdef FETCH_WRAP_FAULT_EN
            fault_q    <= fault_d;
`endif
        end
    end

    assign prog_ctr_out = pc_q;
    assign instr        = instr_q;
    assign instr_pc     = instr_pc_q;
    assign instr_valid  = valid_q;
    assign done         = done_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch against a program-flow reference model
module tb_instr_fetch;

    localparam logic [8:0] HALT = 9'h1FF;
`ifdef FETCH_WRAP_FAULT_EN
    localparam bit FAULT_MODE = 1'b1;
`else
    localparam bit FAULT_MODE = 1'b0;
`endif
    localparam int K_SEQ = 0, K_BR = 1, K_JMP = 2, K_BOTH = 3;
    localparam int E_CAP = 0, E_HALT = 1, E_FAULT = 2;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, stall = 1'b0;
    logic        br_rel = 1'b0, jmp_abs = 1'b0;
    logic [11:0] start_addr = '0, jmp_target = '0;
    logic [7:0]  br_offset = '0;
    logic [11:0] prog_ctr_out, instr_pc;
    logic [8:0]  mach_code, instr;
    logic        instr_valid, done, fault;

    logic [8:0]  rom [4096];
    int          kind [4096];
    logic [11:0] tgt [4096];
    logic [7:0]  ofs [4096];

    logic [20:0] exp_q [$];
    int          tests = 0, fails = 0, issued = 0;
    bit          running = 1'b0;

    instr_fetch dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .stall(stall),
        .br_rel(br_rel), .br_offset(br_offset), .jmp_abs(jmp_abs), .jmp_target(jmp_target),
        .prog_ctr_out(prog_ctr_out), .mach_code(mach_code), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .done(done), .fault(fault)
    );

    assign mach_code = rom[prog_ctr_out];
    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every consumed instruction and checks cycle-level rules.
    bit          have_prev = 1'b0;
    logic        p_stall, p_running, p_valid, p_jmp, p_br;
    logic [8:0]  p_instr;
    logic [11:0] p_pc, p_ipc;
    always @(negedge clk) begin
        logic [20:0] e;
        if (!rst_n) begin
            have_prev = 1'b0;
        end else begin
            if (instr_valid && !stall) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "issue_unexpected", {instr, instr_pc}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check({instr, instr_pc} == e, "issue_word_pc", {instr, instr_pc}, e);
                end
                issued++;
            end
            if (have_prev && p_running && running && p_stall)
                check({prog_ctr_out, instr, instr_pc, instr_valid} == {p_pc, p_instr, p_ipc, p_valid},
                      "stall_hold", {prog_ctr_out, instr, instr_pc, instr_valid},
                      {p_pc, p_instr, p_ipc, p_valid});
            if (have_prev && p_running && running && !p_stall && !done)
                check(instr_valid == !(p_valid && (p_jmp || p_br)), "valid_timing",
                      instr_valid, !(p_valid && (p_jmp || p_br)));
            if (have_prev && p_running && !p_stall && p_valid && p_instr == HALT)
                check(done && !instr_valid, "halt_done", {done, instr_valid}, 2'b10);
            have_prev = 1'b1;
            p_stall = stall; p_running = running; p_valid = instr_valid;
            p_jmp = jmp_abs; p_br = br_rel; p_instr = instr; p_pc = prog_ctr_out; p_ipc = instr_pc;
        end
    end

    // Reference model: walk the program at instruction level, independent of cycles and stalls.
    task automatic build_expected(input logic [11:0] a0, input int cap,
                                  output int n, output int end_kind, output logic [11:0] end_pc);
        int a, k, sofs;
        exp_q.delete();
        a = a0; n = 0; end_kind = E_CAP; end_pc = '0;
        while (n < cap) begin
            if (FAULT_MODE && a == 4095) begin
                end_kind = E_FAULT;
                break;
            end
            exp_q.push_back({rom[a], 12'(a)});
            n++;
            if (rom[a] == HALT) begin
                end_kind = E_HALT;
                end_pc = 12'((a + 1) % 4096);
                break;
            end
            k = kind[a];
            sofs = int'($signed(ofs[a]));
            if (k == K_JMP || k == K_BOTH) a = int'(tgt[a]);
            else if (k == K_BR)            a = ((a + sofs) % 4096 + 4096) % 4096;
            else                           a = (a + 1) % 4096;
        end
    endtask

    task automatic drive_decode();
        int k;
        k = kind[instr_pc];
        jmp_abs    = (k == K_JMP || k == K_BOTH);
        br_rel     = (k == K_BR  || k == K_BOTH);
        jmp_target = tgt[instr_pc];
        br_offset  = ofs[instr_pc];
    endtask

    task automatic clear_tables();
        for (int i = 0; i < 4096; i++) begin
            rom[i] = 9'($urandom_range(0, 510));
            kind[i] = K_SEQ; tgt[i] = 12'($urandom); ofs[i] = 8'($urandom);
        end
    endtask

    task automatic fill_random();
        int r;
        for (int i = 0; i < 4096; i++) begin
            rom[i] = ($urandom_range(0, 19) == 0) ? HALT : 9'($urandom_range(0, 510));
            r = $urandom_range(0, 19);
            kind[i] = (r < 14) ? K_SEQ : (r < 17) ? K_BR : (r < 19) ? K_JMP : K_BOTH;
            tgt[i] = 12'($urandom); ofs[i] = 8'($urandom);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check(prog_ctr_out == 0, {tag, "_pc"}, prog_ctr_out, 0);
        check(instr == 0 && instr_pc == 0, {tag, "_instr"}, {instr, instr_pc}, 0);
        check({instr_valid, done, fault} == 3'b000, {tag, "_flags"}, {instr_valid, done, fault}, 0);
    endtask

    task automatic run_scenario(input logic [11:0] a, input int cap);
        int n_exp, end_kind, cyc, stall_left;
        logic [11:0] end_pc;
        build_expected(a, cap, n_exp, end_kind, end_pc);
        issued = 0;
        @(posedge clk); #1;
        start = 1'b1; start_addr = a; stall = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        check(prog_ctr_out == a, "start_pc", prog_ctr_out, a);
        check({done, fault, instr_valid} == 3'b000, "start_flags", {done, fault, instr_valid}, 0);
        running = 1'b1; cyc = 0; stall_left = 0;
        drive_decode();
        forever begin
            @(posedge clk); #1;
            cyc++;
            drive_decode();
            if (done || issued >= cap || cyc >= 2000) break;
            if (stall_left > 0) begin
                stall = 1'b1; stall_left--;
            end else if ($urandom_range(0, 5) == 0) begin
                stall = 1'b1; stall_left = $urandom_range(0, 2);
            end else begin
                stall = 1'b0;
            end
            start = ($urandom_range(0, 11) == 0);
            start_addr = 12'($urandom);
        end
        start = 1'b0; stall = 1'b0; running = 1'b0;
        if (cyc >= 2000 && !done && issued < cap)
            check(1'b0, "timeout", issued, cap);
        if (end_kind == E_CAP) begin
            check(issued == cap, "cap_count", issued, cap);
            #2 rst_n = 1'b0;
            #1 check_reset_outputs("midrun_reset");
            exp_q.delete();
            @(negedge clk) rst_n = 1'b1;
        end else begin
            check(done == 1'b1, "end_done", done, 1);
            check(fault == (end_kind == E_FAULT), "end_fault", fault, end_kind == E_FAULT);
            check(issued == n_exp && exp_q.size() == 0, "end_count", issued, n_exp);
            if (end_kind == E_HALT)
                check(prog_ctr_out == end_pc, "halt_pc", prog_ctr_out, end_pc);
        end
    endtask

    initial begin
        clear_tables();
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk) rst_n = 1'b1;

        rom[12'h010] = 9'h07E; rom[12'h011] = 9'h066; rom[12'h012] = HALT;
        run_scenario(12'h010, 40);

        clear_tables();
        rom[12'h010] = 9'h07E; rom[12'h011] = 9'h066;
        kind[12'h011] = K_BOTH; tgt[12'h011] = 12'h200; ofs[12'h011] = 8'h05;
        rom[12'h200] = HALT;
        run_scenario(12'h010, 40);

        clear_tables();
        kind[12'h002] = K_BR; ofs[12'h002] = 8'hFD; rom[12'hFFF] = HALT;
        run_scenario(12'h001, 40);

        clear_tables();
        run_scenario(12'hFFA, 10);

        clear_tables();
        run_scenario(12'hFFF, 3);

        for (int s = 0; s < 14; s++) begin
            fill_random();
            run_scenario(($urandom_range(0, 3) == 0) ? 12'($urandom_range(12'hFF0, 12'hFFF))
                                                     : 12'($urandom), 40);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
